// File: rtl/axi_common_types_pkg.sv
// Shared types for the AXI NoC slave-port write path.
package axi_common_types_pkg;
  localparam int NUM_MASTERS = 4;
  localparam int MST_SELW    = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_e;
endpackage

// File: rtl/wr_resp_route_fifo.sv
// In-order FIFO of master indices awaiting their B response.
module wr_resp_route_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot being written when full.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/axi_slave_wr_arbiter.sv
// Write-path arbiter for one slave port: round-robin AW grant, W lock until
// WLAST, in-order B routing back to the issuing master.
module axi_slave_wr_arbiter
  import axi_common_types_pkg::*;
#(
  parameter int NUM_M     = NUM_MASTERS,
  parameter int MAX_OUTST = 4,
  parameter int SELW      = $clog2(NUM_M),
  parameter int CNTW      = $clog2(MAX_OUTST) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [NUM_M-1:0]  m_awvalid,
  output logic [NUM_M-1:0]  m_awready,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [SELW-1:0]   aw_sel,
  input  logic [NUM_M-1:0]  m_wvalid,
  input  logic [NUM_M-1:0]  m_wlast,
  output logic [NUM_M-1:0]  m_wready,
  output logic              s_wvalid,
  output logic              s_wlast,
  input  logic              s_wready,
  output logic [SELW-1:0]   w_sel,
  input  logic              s_bvalid,
  output logic              s_bready,
  output logic [NUM_M-1:0]  m_bvalid,
  input  logic [NUM_M-1:0]  m_bready,
  output logic [SELW-1:0]   b_sel,
  output logic [CNTW-1:0]   outstanding,
  output logic              b_err
);
  arb_state_e      state, state_nxt;
  logic [SELW-1:0] last_grant, pick;
  logic            can_grant, push, pop, fifo_empty, fifo_full;

  // First requester strictly after last, wrapping NUM_M-1 -> 0.
  function automatic logic [SELW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                              input logic [SELW-1:0]  last);
    logic [SELW-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = int'(last) + i;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (!found && req[idx[SELW-1:0]]) begin
        win   = idx[SELW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign pick      = rr_pick(m_awvalid, last_grant);
  assign can_grant = (|m_awvalid) && (outstanding < CNTW'(MAX_OUTST));
  assign push      = (state == DATA) && s_wvalid && s_wready && s_wlast;
  assign pop       = s_bvalid && s_bready;

  always_comb begin
    state_nxt = state;
    s_awvalid = 1'b0;
    m_awready = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    m_wready  = '0;
    case (state)
      IDLE: if (can_grant) state_nxt = ADDR;
      ADDR: begin
        s_awvalid         = m_awvalid[aw_sel];
        m_awready[aw_sel] = s_awready;
        if (s_awvalid && s_awready) state_nxt = DATA;
      end
      DATA: begin
        s_wvalid         = m_wvalid[w_sel];
        s_wlast          = m_wlast[w_sel];
        m_wready[w_sel]  = s_wready;
        if (s_wvalid && s_wready && s_wlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      aw_sel     <= '0;
      w_sel      <= '0;
      last_grant <= SELW'(NUM_M - 1);
      b_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && can_grant) begin
        aw_sel <= pick;
        w_sel  <= pick;
      end
      if (push) last_grant <= w_sel;
      if (s_bvalid && fifo_empty) b_err <= 1'b1;
    end
  end

  // Responses with no recorded owner are never acknowledged.
  always_comb begin
    m_bvalid = '0;
    s_bready = 1'b0;
    if (!fifo_empty) begin
      m_bvalid[b_sel] = s_bvalid;
      s_bready        = m_bready[b_sel];
    end
  end

  wr_resp_route_fifo #(
    .W     (SELW),
    .DEPTH (MAX_OUTST),
    .CW    (CNTW)
  ) u_route_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (push),
    .pop   (pop),
    .din   (w_sel),
    .dout  (b_sel),
    .count (outstanding),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  logic unused_full;
  assign unused_full = fifo_full;
endmodule
